// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path: state
// encodings, opcode/funct constants, ALU select codes and datapath mux codes.
// The ALU select codes are also consumed by the ALU itself.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    // Which ALU decode applies in the current state
    typedef enum logic [1:0] {
        AC_ADD   = 2'd0,
        AC_SUB   = 2'd1,
        AC_RTYPE = 2'd2,
        AC_ITYPE = 2'd3
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SUB = 3'b111;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_REGA = 2'b01;
    localparam logic [1:0] SRC_A_REGB = 2'b10;

    localparam logic [1:0] SRC_B_REGB    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_dec.sv
// ALU operation decoder: maps (state class, opcode, funct) to the 3-bit ALU
// select, flags the shift instructions (which take shamt through operand B)
// and reports whether the R-type funct is one we implement.
module alu_op_dec
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  alu_class_e          cls_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output logic [2:0]          alu_sel_o,
    output logic                shift_o,
    output logic                funct_ok_o
);

    logic [2:0] r_sel;
    logic       r_shift;
    logic [2:0] i_sel;

    // R-type funct decode; unknown funct keeps ADD and clears funct_ok
    always_comb begin
        r_sel      = ALU_ADD;
        r_shift    = 1'b0;
        funct_ok_o = 1'b1;
        case (funct_i)
            FN_ADD:  r_sel = ALU_ADD;
            FN_SUB:  r_sel = ALU_SUB;
            FN_AND:  r_sel = ALU_AND;
            FN_OR:   r_sel = ALU_OR;
            FN_NOR:  r_sel = ALU_NOR;
            FN_SLT:  r_sel = ALU_SLT;
            FN_SLL:  begin r_sel = ALU_SLL; r_shift = 1'b1; end
            FN_SRL:  begin r_sel = ALU_SRL; r_shift = 1'b1; end
            default: funct_ok_o = 1'b0;
        endcase
    end

    // I-type ALU decode; addi and anything else fall back to ADD
    always_comb begin
        case (opcode_i)
            OP_ANDI: i_sel = ALU_AND;
            OP_ORI:  i_sel = ALU_OR;
            OP_SLTI: i_sel = ALU_SLT;
            default: i_sel = ALU_ADD;
        endcase
    end

    // Pick the decode that applies to the current state class
    always_comb begin
        alu_sel_o = ALU_ADD;
        shift_o   = 1'b0;
        case (cls_i)
            AC_ADD:   alu_sel_o = ALU_ADD;
            AC_SUB:   alu_sel_o = ALU_SUB;
            AC_RTYPE: begin alu_sel_o = r_sel; shift_o = r_shift; end
            AC_ITYPE: alu_sel_o = i_sel;
            default:  alu_sel_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset datapath: fetch, decode,
// execute, memory and writeback. Outputs are Moore-decoded from the state
// register, except pc_write in BRANCH (follows zero) and the memory-wait
// gating. Optional build macro MULTICYCLE_MEM_WAIT_EN makes FETCH, MEM_RD
// and MEM_WR wait for mem_ready.
//
// Memory handshake (MULTICYCLE_MEM_WAIT_EN only): a memory state drives its
// strobe (mem_read or mem_write) for every cycle it is occupied; the access
// completes, and the FSM leaves the state, on the rising edge where
// mem_ready=1. pc_write/ir_write in FETCH fire only in that completing cycle.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_sel,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_dbg
);

    state_e     state_q, state_d;
    alu_class_e alu_cls;
    logic [2:0] dec_sel;
    logic       dec_shift;
    logic       dec_funct_ok;
    logic       op_legal;
    logic       mem_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    alu_op_dec #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_alu_op_dec (
        .cls_i      (alu_cls),
        .opcode_i   (opcode),
        .funct_i    (funct),
        .alu_sel_o  (dec_sel),
        .shift_o    (dec_shift),
        .funct_ok_o (dec_funct_ok)
    );

    // Opcodes the datapath supports
    always_comb begin
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    // ALU decode class for the current state
    always_comb begin
        case (state_q)
            S_BRANCH: alu_cls = AC_SUB;
            S_R_EXEC: alu_cls = AC_RTYPE;
            S_I_EXEC: alu_cls = AC_ITYPE;
            default:  alu_cls = AC_ADD;
        endcase
    end

    // Next-state logic; unused encodings fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_RTYPE:                           state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
                    default:                            state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_FETCH;
            end
            S_MEM_RD:   state_d = mem_ok ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ok ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_d = dec_funct_ok ? S_R_WB : S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Output decode; everything held at zero while rst is high
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REGB;
        alu_sel    = ALU_ADD;
        illegal_op = 1'b0;
        if (!rst) begin
            alu_sel = dec_sel;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    pc_write  = mem_ok;
                    ir_write  = mem_ok;
                end
                S_DECODE: begin
                    alu_src_b  = SRC_B_IMM_SH2;
                    illegal_op = !op_legal;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRC_A_REGA;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    // Shifts route rt through port A and IR-derived B carries shamt
                    alu_src_a  = dec_shift ? SRC_A_REGB : SRC_A_REGA;
                    alu_src_b  = dec_shift ? SRC_B_IMM : SRC_B_REGB;
                    illegal_op = !dec_funct_ok;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRC_A_REGA;
                    pc_src    = PC_SRC_ALUOUT;
                    pc_write  = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JUMP: begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = SRC_A_REGA;
                    alu_src_b = SRC_B_IMM;
                end
                S_I_WB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each cycle's expected output
// vector is pushed by the stimulus thread; a monitor pops and compares on
// every falling edge while monitoring is enabled.
module tb_multicycle_ctrl;

    localparam int VW = 22;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic [2:0] alu_sel;
    logic [3:0] state_dbg;

    logic [VW-1:0] exp_q[$];
    string         nm_q[$];
    logic          mon_en;
    int            checks = 0;
    int            errors = 0;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam logic MR_IDLE = 1'b1;
`else
    localparam logic MR_IDLE = 1'b0;
`endif

    logic [VW-1:0] act;
    assign act = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_sel, illegal_op, state_dbg};

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_sel    (alu_sel),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] v(
        input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
        input logic iod, input logic mr, input logic mw, input logic irw,
        input logic rd, input logic m2r, input logic rw,
        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] sel,
        input logic ill);
        return {pcw, pcs, iod, mr, mw, irw, rd, m2r, rw, sa, sb, sel, ill, st};
    endfunction

    // Hand-derived per-state output vectors
    logic [VW-1:0] E_Z, E_FETCH, E_FETCH_WAIT, E_DECODE, E_DECODE_ILL;
    logic [VW-1:0] E_MADDR, E_MRD, E_MWB, E_MWR;
    logic [VW-1:0] E_RSUB, E_RSLL, E_RILL, E_RWB;
    logic [VW-1:0] E_BR_T, E_BR_N, E_JMP, E_IORI, E_ISLT, E_IWB;

    // Driver: push the expectation for the current cycle, then advance
    task automatic step(input logic [VW-1:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: no expectation, actual=%h", act);
            end else begin
                logic [VW-1:0] e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h (state act=%0d req=%0d)",
                             n, act, e, act[3:0], e[3:0]);
                end
            end
        end
    end

    initial begin
        E_Z          = v(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        E_FETCH      = v(4'd0, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0);
        E_FETCH_WAIT = v(4'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0);
        E_DECODE     = v(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 0);
        E_DECODE_ILL = v(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 1);
        E_MADDR      = v(4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 0);
        E_MRD        = v(4'd3, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        E_MWB        = v(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 0);
        E_MWR        = v(4'd5, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        E_RSUB       = v(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b111, 0);
        E_RSLL       = v(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 3'b101, 0);
        E_RILL       = v(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 1);
        E_RWB        = v(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3'b000, 0);
        E_BR_T       = v(4'd8, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b111, 0);
        E_BR_N       = v(4'd8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b111, 0);
        E_JMP        = v(4'd9, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        E_IORI       = v(4'd10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b010, 0);
        E_ISLT       = v(4'd10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b100, 0);
        E_IWB        = v(4'd11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0);

        rst = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
        mem_ready = MR_IDLE; mon_en = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state
        step(E_Z, "reset0");
        step(E_Z, "reset1");
        rst = 1'b0;

        // lw: 5 cycles
        opcode = 6'b100011;
        step(E_FETCH, "lw.fetch"); step(E_DECODE, "lw.decode");
        step(E_MADDR, "lw.maddr"); step(E_MRD, "lw.memrd"); step(E_MWB, "lw.memwb");

        // sw: 4 cycles
        opcode = 6'b101011;
        step(E_FETCH, "sw.fetch"); step(E_DECODE, "sw.decode");
        step(E_MADDR, "sw.maddr"); step(E_MWR, "sw.memwr");

        // R-type sub and sll
        opcode = 6'b000000; funct = 6'b100010;
        step(E_FETCH, "sub.fetch"); step(E_DECODE, "sub.decode");
        step(E_RSUB, "sub.exec"); step(E_RWB, "sub.wb");
        funct = 6'b000000;
        step(E_FETCH, "sll.fetch"); step(E_DECODE, "sll.decode");
        step(E_RSLL, "sll.exec"); step(E_RWB, "sll.wb");

        // Branches and jump
        opcode = 6'b000100; zero = 1'b1;
        step(E_FETCH, "beq.fetch"); step(E_DECODE, "beq.decode"); step(E_BR_T, "beq.z1");
        opcode = 6'b000101;
        step(E_FETCH, "bne.fetch"); step(E_DECODE, "bne.decode"); step(E_BR_N, "bne.z1");
        zero = 1'b0;
        step(E_FETCH, "bne0.fetch"); step(E_DECODE, "bne0.decode"); step(E_BR_T, "bne.z0");
        opcode = 6'b000100;
        step(E_FETCH, "beq0.fetch"); step(E_DECODE, "beq0.decode"); step(E_BR_N, "beq.z0");
        opcode = 6'b000010;
        step(E_FETCH, "j.fetch"); step(E_DECODE, "j.decode"); step(E_JMP, "j.jump");

        // I-type ori and slti
        opcode = 6'b001101;
        step(E_FETCH, "ori.fetch"); step(E_DECODE, "ori.decode");
        step(E_IORI, "ori.exec"); step(E_IWB, "ori.wb");
        opcode = 6'b001010;
        step(E_FETCH, "slti.fetch"); step(E_DECODE, "slti.decode");
        step(E_ISLT, "slti.exec"); step(E_IWB, "slti.wb");

        // Illegal opcode, then illegal R funct
        opcode = 6'b111111;
        step(E_FETCH, "illop.fetch"); step(E_DECODE_ILL, "illop.decode");
        opcode = 6'b000000; funct = 6'b001000;
        step(E_FETCH, "illfn.fetch"); step(E_DECODE, "illfn.decode");
        step(E_RILL, "illfn.exec");

        // Reset for 3 cycles in the middle of R_EXEC
        funct = 6'b100010;
        step(E_FETCH, "rst.fetch"); step(E_DECODE, "rst.decode");
        rst = 1'b1;
        step(E_Z, "rst.hold0"); step(E_Z, "rst.hold1"); step(E_Z, "rst.hold2");
        rst = 1'b0;
        step(E_FETCH, "rst.refetch"); step(E_DECODE, "rst.redecode");
        step(E_RSUB, "rst.exec"); step(E_RWB, "rst.wb");

`ifdef MULTICYCLE_MEM_WAIT_EN
        // FETCH stalls for 4 cycles waiting on memory
        mem_ready = 1'b0; opcode = 6'b000010;
        for (int i = 0; i < 4; i++) step(E_FETCH_WAIT, "wait.fetch");
        mem_ready = 1'b1;
        step(E_FETCH, "wait.done"); step(E_DECODE, "wait.decode"); step(E_JMP, "wait.jump");
`endif

        step(E_FETCH, "end.fetch");
        mon_en = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: actual=%0d required=0 pending expectations", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset datapath. Sequences fetch, decode, execute, memory and writeback.
Drives the ALU's 3-bit operation select and operand muxes, and consumes the ALU zero flag.
It is the producer side of the ALU select/Z interface. Sits between the instruction register and the datapath muxes/enables.

Parameters:
OPCODE_W, 6, instruction opcode field width
FUNCT_W, 6, R-type funct field width
STATE_W, 4, state register width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  IR[31:26]
funct  in  FUNCT_W  IR[5:0]
zero  in  1  ALU Z flag (ALU result == 0)
mem_ready  in  1  memory handshake; used only with the optional feature
pc_write  out  1  PC load enable
pc_src  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  2  00 PC, 01 regA(rs), 10 regB(rt)
alu_src_b  out  2  00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
alu_sel  out  3  ALU op: 000 add, 001 and, 010 or, 011 nor, 100 slt, 101 sll, 110 srl, 111 sub
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
state_dbg  out  STATE_W  current state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset behaviour: on rst at a clk edge, state <= FETCH.
  - While rst is high, all enables/strobes (pc_write, mem_read, mem_write, ir_write, reg_write), illegal_op and every mux select are forced 0, and alu_sel = 000.
  - First cycle after rst deasserts is FETCH. Reset mid-instruction aborts with no further writes.
- Output style: Moore outputs decoded from state; the exceptions are pc_write in BRANCH (depends on zero) and the optional mem_ready gating.
- States and transitions:
  - FETCH(0): mem_read, ir_write, src_a=00, src_b=01, add, pc_src=00, pc_write. Next: DECODE.
  - DECODE(1): src_a=00, src_b=11, add (branch target into ALUOut). Next by opcode:
    - lw/sw -> MEM_ADDR
    - R-type -> R_EXEC
    - beq/bne -> BRANCH
    - j -> JUMP
    - addi/andi/ori/slti -> I_EXEC
    - otherwise illegal_op=1 and next FETCH
  - MEM_ADDR(2): src_a=01, src_b=10, add. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(3): mem_read, i_or_d=1. Next: MEM_WB.
  - MEM_WB(4): reg_write, reg_dst=0, mem_to_reg=1. Next: FETCH.
  - MEM_WR(5): mem_write, i_or_d=1. Next: FETCH.
  - R_EXEC(6): src_a=01, src_b=00, alu_sel from funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, 000000 sll, 000010 srl
    - For sll/srl: src_a=10, src_b=10, so B[10:6] carries shamt.
    - Unknown funct: illegal_op pulse, next FETCH, no writeback.
    - Next: R_WB.
  - R_WB(7): reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH(8): src_a=01, src_b=00, sub, pc_src=01. pc_write = zero for beq, ~zero for bne. Next: FETCH.
  - JUMP(9): pc_src=10, pc_write. Next: FETCH.
  - I_EXEC(10): src_a=01, src_b=10. alu_sel: addi add, andi and, ori or, slti slt. Immediates are sign-extended for all I-type. Next: I_WB.
  - I_WB(11): reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Unused encodings (12–15): return to FETCH with all outputs 0.
- Opcodes: R 000000, j 000010, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011.
- Cycle counts: lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, j 3, illegal 2.

Optional Feature:
Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined: FETCH, MEM_RD and MEM_WR hold until mem_ready=1.
  - Strobes stay asserted while waiting.
  - pc_write and ir_write in FETCH assert only in the cycle mem_ready=1.
  - Transition happens on that edge.
  - rst during a wait goes to FETCH.
- Undefined: mem_ready is ignored and each memory state lasts exactly one cycle.

Decomposition:
- Shared package ctrl_pkg:
  - state encodings
  - opcode and funct constants
  - ALU select codes (also used by the ALU)
  - alu_src_a/alu_src_b/pc_src encodings
- Sub-module alu_op_dec: combinational map (state class, opcode, funct) -> alu_sel, shift flag, funct-legal flag.

Test Plan:
- Reset: rst high 3 cycles mid-R_EXEC -> all outputs 0, state_dbg=0 on release. Next cycle FETCH with pc_write=1, ir_write=1, alu_sel=000.
- lw (opcode 100011) -> states 0,1,2,3,4,0. MEM_RD has i_or_d=1. MEM_WB has reg_write=1, mem_to_reg=1. 5 cycles total.
- R-type sub (funct 100010) -> R_EXEC alu_sel=111, R_WB reg_dst=1. sll (funct 000000) -> alu_src_a=10, alu_src_b=10, alu_sel=101.
- beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_write=0. j -> pc_src=10, pc_write=1.
- Illegal opcode 111111 and R funct 001000 -> illegal_op single-cycle pulse, no reg_write/mem_write, back to FETCH.
- With MULTICYCLE_MEM_WAIT_EN, mem_ready low 4 cycles in FETCH -> state held, mem_read=1, pc_write=0. pc_write/ir_write pulse once when mem_ready=1.
